// File: rtl/mux21_rr_arbiter.sv
// Purpose: round-robin select stage in front of the 4-bit 2:1 mux; optional burst grants via ARB_BURST_EN.
// Latency: 1 cycle from accepted input word to out_valid.
// Backpressure: pass-through ready; a held output word (out_valid & !out_ready) blocks both requesters.
module mux21_rr_arbiter #(
  parameter int DATA_W    = 4,
  parameter int BURST_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [0:DATA_W-1] a_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [0:DATA_W-1] b_data,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              s,
  output logic [0:DATA_W-1] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // Burst length must fit the 4-bit counter and allow at least one grant.
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_check
    $error("BURST_LEN out of range 1..15");
  end

  logic              last_a;    // 1: last grant went to A, 0: to B
  logic              load;
  logic              gnt_a;
  logic              gnt_b;
  logic              any_gnt;
  logic              sel_a;
  logic [0:DATA_W-1] mux_data;

`ifdef ARB_BURST_EN
  localparam logic [3:0] BURST_LIM = 4'(BURST_LEN);
  logic [3:0] burst_cnt;
  logic       keep;
`endif

  // Grant decision: single requester wins outright, contention goes round-robin.
  always_comb begin
    load  = !out_valid | out_ready;
    gnt_a = 1'b0;
    gnt_b = 1'b0;
`ifdef ARB_BURST_EN
    // A zero count means no burst is running yet, so contention switches away from last_a.
    keep  = (burst_cnt != 4'd0) && (burst_cnt < BURST_LIM);
`endif
    if (a_valid && b_valid) begin
`ifdef ARB_BURST_EN
      gnt_a = keep ? last_a : !last_a;
`else
      gnt_a = !last_a;
`endif
      gnt_b = !gnt_a;
    end else begin
      gnt_a = a_valid;
      gnt_b = b_valid;
    end
  end

  // Select and data path: with no request the select parks on the last grant.
  always_comb begin
    any_gnt  = gnt_a | gnt_b;
    sel_a    = gnt_a | (!any_gnt & last_a);
    mux_data = sel_a ? a_data : b_data;
  end

  // Outputs toward requesters and mux are forced low while reset is asserted.
  always_comb begin
    s       = rst_n & sel_a;
    a_ready = rst_n & load & gnt_a;
    b_ready = rst_n & load & gnt_b;
  end

  // Single-entry output register; a drain and a new load on the same edge leave no gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      last_a    <= 1'b0;
    end else if (load && any_gnt) begin
      out_data  <= mux_data;
      out_valid <= 1'b1;
      last_a    <= gnt_a;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_BURST_EN
  // Count consecutive grants to the same requester; restart at 1 on a switch, saturate at 15.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= 4'd0;
    end else if (load && any_gnt) begin
      if ((gnt_a == last_a) && (burst_cnt != 4'd0)) begin
        burst_cnt <= (burst_cnt == 4'hF) ? burst_cnt : burst_cnt + 4'd1;
      end else begin
        burst_cnt <= 4'd1;
      end
    end
  end
`endif

endmodule

// File: doc/mux21_rr_arbiter.md
Name: mux21_rr_arbiter

Overview:
- Upstream select and arbitration stage for the 4-bit 2:1 mux (BR_4_MUX21).
- Two valid/ready requesters (A, B) each offer a 4-bit word. Round-robin arbitration decides which one is granted.
- Drives select `s` to the mux and registers the selected word into a single-entry output stage with valid/ready toward the consumer.
- The block computes the mux function internally for its own output register. `s`, `a_data` and `b_data` are also exported so the existing mux can sit alongside.

Parameters:
- DATA_W, 4, data word width. All data ports are declared `[0:DATA_W-1]`; bit 0 is the MSB.
- BURST_LEN, 2, maximum consecutive grants to one requester. Used only with ARB_BURST_EN; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  synchronous reset, active-low, sampled on rising clk edge
- a_data  input  DATA_W  requester A word
- a_valid  input  1  A offers a word
- a_ready  output  1  A word accepted this cycle
- b_data  input  DATA_W  requester B word
- b_valid  input  1  B offers a word
- b_ready  output  1  B word accepted this cycle
- s  output  1  mux select: 1 = A, 0 = B
- out_data  output  DATA_W  registered selected word
- out_valid  output  1  out_data holds a word
- out_ready  input  1  consumer accepts out_data

Behaviour:
- Clock and reset:
  - Clock is clk. Reset is rst_n: synchronous, active-low. No asynchronous terms.
- Reset values:
  - out_valid=0, out_data=0.
  - last_grant=B, so A wins the first contention.
  - s=0, a_ready=0, b_ready=0.
  - Burst counter=0.
- Load enable:
  - load = !out_valid | out_ready. This is a pass-through ready, giving full throughput with no bubble.
- Grant (combinational):
  - Only A valid -> A. Only B valid -> B.
  - Both valid -> the requester that is not last_grant.
  - Neither valid -> no grant; s holds last_grant.
- Select:
  - s = 1 when the grant is A, or when there is no request and last_grant=A. Otherwise s = 0.
- Ready outputs:
  - a_ready = load & grant_A. b_ready = load & grant_B.
  - Never both 1 in the same cycle.
  - Ready may depend combinationally on valid. Valid must not depend on ready.
- Transfer on a clock edge:
  - If load and a grant exist: out_data <= granted word, out_valid <= 1, last_grant <= granted requester.
  - Else if out_ready: out_valid <= 0. out_data holds its value; it is not cleared.
  - Else: hold.
- Latency: 1 cycle from accepted input to out_valid.
- Sustained throughput: 1 word/cycle while out_ready=1.
- Backpressure:
  - out_valid=1 and out_ready=0 -> both readys are 0.
  - out_data and out_valid stay stable until accepted.
- Simultaneous output drain and new grant: the new word replaces the old one in the same edge, with no gap.
- Reset mid-operation: the pending output word is discarded, all state returns to reset values, and the next contention grants A.
- Arbitration fairness: with both requesters continuously valid, grants strictly alternate A,B,A,B.

Optional Feature:
- Macro: ARB_BURST_EN.
- Defined:
  - A 4-bit burst counter tracks consecutive grants to last_grant.
  - Under contention, last_grant keeps the grant while counter < BURST_LEN.
  - When the counter reaches BURST_LEN, the grant switches and the counter resets to 1.
  - Counter resets to 1 on any grant switch. It holds when no transfer occurs.
  - Both valid continuously with BURST_LEN=2 -> A,A,B,B,A,A...
- Undefined: no counter logic is synthesized; strict alternation as described in Behaviour.

Test Plan:
- Reset: rst_n=0 for 2 cycles with a_valid=b_valid=1 -> out_valid=0, out_data=4'b0000, a_ready=b_ready=0, s=0. First cycle after release: s=1, a_ready=1.
- Single requester: a_data=4'b0001, a_valid=1, b_valid=0, out_ready=1 -> s=1; next cycle out_data=4'b0001, out_valid=1. Repeat with only b_data=4'b1000 -> s=0, out_data=4'b1000.
- Contention: a_data=0001, b_data=1000, both valid for 4 cycles, out_ready=1 -> out_data sequence 0001,1000,0001,1000. With ARB_BURST_EN and BURST_LEN=2 -> 0001,0001,1000,1000.
- Backpressure: out_valid=1 holding 0001, out_ready=0 for 3 cycles with both valid -> out_data stays 0001, a_ready=b_ready=0 throughout. Raise out_ready -> next word 1000 on the following edge, with no bubble.
- Idle hold: grant B once, then a_valid=b_valid=0 -> s stays 0. out_valid drops to 0 after acceptance; out_data keeps 1000.
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> next edge out_valid=0. After release with both valid, the first grant is A (s=1).
